// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the access-size and FSM encodings plus beat-count arithmetic.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic        store;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

    // Number of memory beats needed to move 2^size bytes over a bus_bytes-wide path.
    function automatic int unsigned lsu_nbeats(input logic [1:0] size, input int unsigned bus_bytes);
        int unsigned nbytes;
        nbytes = 32'd1 << size;
        return (nbytes > bus_bytes) ? nbytes / bus_bytes : 32'd1;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of assembled load data to 32 bits.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] data,
    output logic [31:0] ext
);

    always_comb begin
        ext = data;
        case (size_e'(size))
            SZ_B:    ext = {{24{~uns & data[7]}}, data[7:0]};
            SZ_H:    ext = {{16{~uns & data[15]}}, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: splits a byte/half/word access into bus-width beats,
// assembles load data little-endian and returns one response per request.
module lsu
    import lsu_pkg::*;
#(
    parameter int BUS_BYTES  = 1,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_store,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [31:0]             i_req_wdata,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [31:0]             o_resp_rdata,
    output logic                    o_resp_err,
    output logic                    o_mem_valid,
    input  logic                    i_mem_ready,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic                    o_mem_write,
    output logic [BUS_BYTES-1:0]    o_mem_be,
    output logic [8*BUS_BYTES-1:0]  o_mem_wdata,
    input  logic [8*BUS_BYTES-1:0]  i_mem_data
);

    localparam int LANE_SH = $clog2(BUS_BYTES);

    state_e                  state, state_nxt;
    req_t                    req_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              beat_q;
    logic [31:0]             asm_q, asm_nxt;
    logic [31:0]             rdata_q;
    logic [31:0]             ext_data;
    logic                    err_q;
    logic                    illegal;
    logic                    last_beat;
    logic [1:0]              byte_base;
    logic [2:0]              nbytes;
    logic [BUS_BYTES-1:0]    be;
    logic [8*BUS_BYTES-1:0]  wlanes;

    always_comb begin
        case (i_req_size)
            2'd0:    illegal = 1'b0;
            2'd1:    illegal = i_req_addr[0];
            2'd2:    illegal = |i_req_addr[1:0];
            default: illegal = 1'b1;
        endcase
    end

    // Byte offset of the current beat within the request; never exceeds 3.
    assign byte_base = 2'(beat_q << LANE_SH);
    assign nbytes    = 3'd1 << req_q.size;
    assign last_beat = ((32'(beat_q) + 32'd1) == lsu_nbeats(req_q.size, BUS_BYTES));

    always_comb begin
        be      = '0;
        wlanes  = '0;
        asm_nxt = asm_q;
        for (int j = 0; j < BUS_BYTES; j++) begin
            if (j < int'(nbytes)) begin
                be[j]                                   = 1'b1;
                wlanes[8*j +: 8]                        = req_q.wdata[8*(int'(byte_base) + j) +: 8];
                asm_nxt[8*(int'(byte_base) + j) +: 8]   = i_mem_data[8*j +: 8];
            end
        end
        // Lanes are only driven while a beat is actually offered.
        if (state != ST_ACCESS) begin
            be     = '0;
            wlanes = '0;
        end
        if (!req_q.store) wlanes = '0;
    end

    lsu_extend u_extend (
        .size (req_q.size),
        .uns  (req_q.uns),
        .data (asm_nxt),
        .ext  (ext_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (i_req_valid) state_nxt = illegal ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (i_mem_ready && last_beat) state_nxt = ST_RESP;
            ST_RESP:   if (i_resp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_q   <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        req_q   <= '{store: i_req_store, size: i_req_size,
                                     uns: i_req_unsigned, wdata: i_req_wdata};
                        addr_q  <= i_req_addr;
                        beat_q  <= '0;
                        asm_q   <= '0;
                        rdata_q <= '0;
                        err_q   <= illegal;
                    end
                end
                ST_ACCESS: begin
                    if (i_mem_ready) begin
                        beat_q <= last_beat ? 2'd0 : beat_q + 2'd1;
                        if (!req_q.store) asm_q <= asm_nxt;
                        if (last_beat) rdata_q <= req_q.store ? 32'd0 : ext_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready  = (state == ST_IDLE);
    assign o_mem_valid  = (state == ST_ACCESS);
    assign o_mem_write  = o_mem_valid & req_q.store;
    assign o_mem_addr   = o_mem_valid ? addr_q + ADDR_WIDTH'(byte_base) : '0;
    assign o_mem_be     = be;
    assign o_mem_wdata  = wlanes;
    assign o_resp_valid = (state == ST_RESP);
    assign o_resp_err   = o_resp_valid & err_q;
    assign o_resp_rdata = o_resp_valid ? rdata_q : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu at bus widths 1, 2 and 4 against a byte-array memory model.
module tb_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_bb
        localparam int BB = 1 << g;

        logic               rst;
        logic               req_valid, req_ready, req_store, req_uns;
        logic [1:0]         req_size;
        logic [31:0]        req_addr, req_wdata;
        logic               resp_valid, resp_ready, resp_err;
        logic [31:0]        resp_rdata;
        logic               mem_valid, mem_ready, mem_write;
        logic [31:0]        mem_addr;
        logic [BB-1:0]      mem_be;
        logic [8*BB-1:0]    mem_wdata, mem_data;

        // phys is what the DUT actually wrote; ref_m is what the rules say it should hold.
        bit [7:0] phys  [256];
        bit [7:0] ref_m [256];

        lsu #(.BUS_BYTES(BB), .ADDR_WIDTH(32)) u_dut (
            .i_clk          (clk),
            .i_rst          (rst),
            .i_req_valid    (req_valid),
            .o_req_ready    (req_ready),
            .i_req_store    (req_store),
            .i_req_size     (req_size),
            .i_req_unsigned (req_uns),
            .i_req_addr     (req_addr),
            .i_req_wdata    (req_wdata),
            .o_resp_valid   (resp_valid),
            .i_resp_ready   (resp_ready),
            .o_resp_rdata   (resp_rdata),
            .o_resp_err     (resp_err),
            .o_mem_valid    (mem_valid),
            .i_mem_ready    (mem_ready),
            .o_mem_addr     (mem_addr),
            .o_mem_write    (mem_write),
            .o_mem_be       (mem_be),
            .o_mem_wdata    (mem_wdata),
            .i_mem_data     (mem_data)
        );

        function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic un, input logic [31:0] a);
            int          nb;
            logic [31:0] v;
            nb = 1 << sz;
            v  = 32'd0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_m[8'(a + 32'(i))]) << (8 * i));
            if (nb < 4 && !un && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
            return v;
        endfunction

        // Entered and left just after a falling edge.
        task automatic run_txn(input logic st, input logic [1:0] sz, input logic un,
                               input logic [31:0] a, input logic [31:0] wd,
                               input int mw, input int rw, output logic [31:0] got);
            string          t;
            bit             ill;
            int             nb, nbeats, nl;
            logic [31:0]    exp_r, ea, junk;
            logic [BB-1:0]  ebe;
            logic [8*BB-1:0] ewd;

            t      = $sformatf("bb%0d %s sz%0d @%0h", BB, st ? "st" : "ld", sz, a);
            ill    = (sz == 2'd3) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0);
            nb     = 1 << sz;
            nbeats = (nb > BB) ? nb / BB : 1;
            nl     = (nb < BB) ? nb : BB;
            exp_r  = 32'd0;
            if (!ill) begin
                if (st) for (int i = 0; i < nb; i++) ref_m[8'(a + 32'(i))] = wd[8*i +: 8];
                else    exp_r = ref_load(sz, un, a);
            end

            chk({t, " req_ready idle"}, req_ready, 1'b1);
            req_valid = 1'b1; req_store = st; req_size = sz; req_uns = un;
            req_addr = a; req_wdata = wd;
            @(negedge clk);
            req_valid = 1'b0;
            req_store = ~st; req_size = 2'($urandom); req_uns = ~un;
            req_addr = $urandom; req_wdata = $urandom;
            chk({t, " req_ready busy"}, req_ready, 1'b0);

            if (ill) begin
                chk({t, " no beat"}, mem_valid, 1'b0);
            end else begin
                for (int k = 0; k < nbeats; k++) begin
                    ea  = a + 32'(k * BB);
                    ebe = '0;
                    ewd = '0;
                    for (int j = 0; j < BB; j++) begin
                        if (j < nl) begin
                            ebe[j]        = 1'b1;
                            ewd[8*j +: 8] = wd[8*(k*BB + j) +: 8];
                        end
                    end
                    for (int w = 0; w <= mw; w++) begin
                        chk({t, $sformatf(" b%0d mem_valid", k)}, mem_valid, 1'b1);
                        chk({t, $sformatf(" b%0d addr", k)}, mem_addr, ea);
                        chk({t, $sformatf(" b%0d be", k)}, mem_be, ebe);
                        chk({t, $sformatf(" b%0d write", k)}, mem_write, st);
                        if (st) chk({t, $sformatf(" b%0d wdata", k)}, mem_wdata, ewd);
                        chk({t, $sformatf(" b%0d resp early", k)}, resp_valid, 1'b0);
                        if (w == mw) begin
                            mem_ready = 1'b1;
                            for (int j = 0; j < BB; j++) mem_data[8*j +: 8] = phys[8'(ea + 32'(j))];
                            if (st) for (int j = 0; j < BB; j++)
                                if (mem_be[j]) phys[8'(ea + 32'(j))] = mem_wdata[8*j +: 8];
                        end else begin
                            junk     = $urandom;
                            mem_data = junk[8*BB-1:0];
                        end
                        @(negedge clk);
                        mem_ready = 1'b0;
                    end
                end
            end

            got = 32'd0;
            for (int w = 0; w <= rw; w++) begin
                chk({t, " resp_valid"}, resp_valid, 1'b1);
                chk({t, " resp_err"}, resp_err, ill);
                chk({t, " rdata"}, resp_rdata, exp_r);
                chk({t, " mem idle in resp"}, mem_valid, 1'b0);
                chk({t, " req_ready in resp"}, req_ready, 1'b0);
                got = resp_rdata;
                resp_ready = (w == rw);
                @(negedge clk);
                resp_ready = 1'b0;
            end
            chk({t, " back to idle"}, req_ready, 1'b1);
            chk({t, " resp dropped"}, resp_valid, 1'b0);
        endtask

        task automatic reset_mid_access();
            string t;
            t = $sformatf("bb%0d reset mid-access", BB);
            req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_uns = 1'b0;
            req_addr = 32'h40; req_wdata = 32'd0;
            @(negedge clk);
            req_valid = 1'b0;
            chk({t, " in access"}, mem_valid, 1'b1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk({t, " mem_valid"}, mem_valid, 1'b0);
            chk({t, " req_ready"}, req_ready, 1'b1);
            for (int c = 0; c < 3; c++) begin
                chk({t, " no resp"}, resp_valid, 1'b0);
                @(negedge clk);
            end
        endtask

        initial begin
            logic [31:0] got, a, wd;
            logic [1:0]  sz;
            logic        st, un;
            string       t;

            t = $sformatf("bb%0d", BB);
            rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_uns = 1'b0;
            req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0; mem_ready = 1'b0; mem_data = '0;
            for (int i = 0; i < 256; i++) begin
                phys[i]  = 8'($urandom);
                ref_m[i] = phys[i];
            end
            repeat (2) @(negedge clk);
            chk({t, " rst req_ready"}, req_ready, 1'b1);
            chk({t, " rst mem_valid"}, mem_valid, 1'b0);
            chk({t, " rst resp_valid"}, resp_valid, 1'b0);
            chk({t, " rst resp_err"}, resp_err, 1'b0);
            chk({t, " rst mem_write"}, mem_write, 1'b0);
            chk({t, " rst mem_addr"}, mem_addr, 32'd0);
            chk({t, " rst mem_be"}, mem_be, '0);
            chk({t, " rst mem_wdata"}, mem_wdata, '0);
            chk({t, " rst rdata"}, resp_rdata, 32'd0);
            rst = 1'b0;
            @(negedge clk);

            // Word load of 0x80,0,0,0 at 0x100 (low 8 address bits index the model).
            phys[0] = 8'h80; phys[1] = 8'h00; phys[2] = 8'h00; phys[3] = 8'h00;
            for (int i = 0; i < 4; i++) ref_m[i] = phys[i];
            run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 0, 0, got);
            chk({t, " lw 0x100 value"}, got, 32'h0000_0080);

            phys[7] = 8'h80; ref_m[7] = 8'h80;
            run_txn(1'b0, 2'd0, 1'b0, 32'h7, 32'd0, 0, 0, got);
            chk({t, " lb signed value"}, got, 32'hFFFF_FF80);
            run_txn(1'b0, 2'd0, 1'b1, 32'h7, 32'd0, 1, 0, got);
            chk({t, " lbu value"}, got, 32'h0000_0080);

            run_txn(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, 0, 0, got);
            chk({t, " sw rdata zero"}, got, 32'd0);
            run_txn(1'b0, 2'd2, 1'b1, 32'h20, 32'd0, 0, 1, got);
            chk({t, " lw after sw"}, got, 32'hDEAD_BEEF);

            run_txn(1'b0, 2'd1, 1'b0, 32'h101, 32'd0, 0, 0, got);
            chk({t, " misaligned lh rdata"}, got, 32'd0);
            run_txn(1'b1, 2'd3, 1'b0, 32'h40, 32'h1234_5678, 0, 1, got);

            run_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 3, 2, got);
            run_txn(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFE, 32'h0000_A55A, 2, 0, got);
            run_txn(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFE, 32'd0, 0, 0, got);
            chk({t, " lh high addr"}, got, 32'hFFFF_A55A);

            reset_mid_access();

            for (int n = 0; n < 40; n++) begin
                st = 1'($urandom);
                un = 1'($urandom);
                sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                a  = $urandom;
                if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
                wd = $urandom;
                run_txn(st, sz, un, a, wd, $urandom_range(0, 3), $urandom_range(0, 2), got);
            end

            done_cnt++;
        end
    end

    initial begin
        for (int c = 0; c < 40000; c++) begin
            @(negedge clk);
            if (done_cnt == 3) break;
        end
        chk("all widths finished", done_cnt, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
